// File: rtl/fifo_rd_stream_if.sv
// Read-side bundle for fifo_rd_stream: simple_fifo pop port plus the downstream valid/ready stream.
// master = the read engine, slave = the FIFO and consumer it connects to.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic                  fifo_rden;
  logic [DATA_WIDTH-1:0] fifo_rddata;
  logic                  fifo_data_valid;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    input  fifo_empty, fifo_rddata, fifo_data_valid, m_ready,
    output fifo_rden, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_rddata, fifo_data_valid, m_ready,
    input  fifo_rden, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read engine for simple_fifo: credit-based prefetch into a small circular buffer, valid/ready output, flush drain.
// Optional FIFO_RD_STATS_EN adds saturating word_cnt / stall_cnt outputs.
//
//   state    | meaning
//   ST_RUN   | prefetch with credit check, buffer words, stream them out
//   ST_FLUSH | pop FIFO unconditionally, discard every returned word, wait for empty and no reads in flight
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1   // legal range 1..3
) (
  input  logic                    clk,
  input  logic                    rst,
  fifo_rd_stream_if.master        bus,
  input  logic                    flush,
  output logic                    flush_done,
  output logic                    protocol_err
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]             word_cnt,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int BUF_DEPTH = RD_LATENCY + 1;
  localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      buf_count, inflight;
  logic [CNT_W:0]        credit_used;
  logic                  m_valid_c, pop_now, dv_ok, rden, flush_exit, flush_enter;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign m_valid_c   = (state_q == ST_RUN) && (buf_count != '0);
  assign pop_now     = m_valid_c && bus.m_ready;
  // A returned word only counts against a read we actually issued.
  assign dv_ok       = bus.fifo_data_valid && (inflight != '0);
  assign flush_enter = (state_q == ST_RUN) && flush;
  assign credit_used = {1'b0, buf_count} + {1'b0, inflight} - (CNT_W+1)'(pop_now);

  assign bus.fifo_rden = rden;
  assign bus.m_valid   = m_valid_c;
  assign bus.m_data    = buf_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rden       = 1'b0;
    flush_exit = 1'b0;
    case (state_q)
      ST_RUN: begin
        rden = !bus.fifo_empty && (credit_used < (CNT_W+1)'(BUF_DEPTH));
        if (flush) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        rden = !bus.fifo_empty;
        if (bus.fifo_empty && (inflight == '0)) begin
          flush_exit = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      buf_count    <= '0;
      inflight     <= '0;
      flush_done   <= 1'b0;
      protocol_err <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else begin
      flush_done <= flush_exit;
      inflight   <= inflight + CNT_W'(rden) - CNT_W'(dv_ok);
      if (bus.fifo_data_valid && (inflight == '0)) begin
        protocol_err <= 1'b1;
      end
      // Entering flush throws away the buffer, including a word landing this cycle.
      if (flush_enter) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        buf_count <= '0;
      end else if (state_q == ST_RUN) begin
        if (dv_ok) begin
          buf_mem[wr_ptr] <= bus.fifo_rddata;
          wr_ptr          <= ptr_inc(wr_ptr);
        end
        if (pop_now) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        buf_count <= buf_count + CNT_W'(dv_ok) - CNT_W'(pop_now);
      end
    end
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop_now && (word_cnt != '1)) begin
        word_cnt <= word_cnt + 32'd1;
      end
      if (m_valid_c && !bus.m_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
